// File: rtl/stepper_sched.sv
// stepper_sched: parses two-byte move commands from the serial byte stream,
// keeps a remaining-step count and direction per motor, and on every step
// tick issues one control-byte write per active motor in round-robin order
// (motor 0 first) on the shared control bus.
module stepper_sched #(
  parameter int STEP_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [7:0] ctrl_byte,
  output logic       ctrl_wr,
  output logic [3:0] busy,
  output logic       cmd_err
);

  localparam int CW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(STEP_DIV - 1);
  localparam logic [CW-1:0] TICK_ONE  = CW'(1);

  typedef enum logic {
    P_HDR = 1'b0,
    P_CNT = 1'b1
  } parse_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } sched_t;

  // Parser state
  parse_t          pstate;
  logic [1:0]      idx_lat;
  logic            dir_lat;

  // Tick generation
  logic [CW-1:0]   tick_cnt;
  logic            tick;

  // Scheduler state. slot holds the next slot to serve while in ISSUE;
  // slot 0 is served on the tick edge itself so that slot i's write is
  // visible i+1 cycles after the tick.
  sched_t          sstate;
  logic [1:0]      slot;

  // Per-motor state
  logic [3:0][7:0] rem;
  logic [3:0]      dir;

  // Next-state helpers
  logic            load;
  logic            proc_en;
  logic [1:0]      proc_slot;
  logic            issue;
  logic [7:0]      issue_byte;
  logic [3:0][7:0] rem_next;
  logic [3:0]      dir_next;
  logic [3:0]      busy_next;

  // Decode the current strobes: count-byte load and tick.
  always_comb begin
    load = (pstate == P_CNT) && rx_valid;
    tick = (tick_cnt == TICK_LAST);
  end

  // Select the slot being served this cycle and decide whether it writes.
  always_comb begin
    if (sstate == S_ISSUE) begin
      proc_en   = 1'b1;
      proc_slot = slot;
    end else begin
      proc_en   = tick;
      proc_slot = 2'd0;
    end
    issue      = proc_en && (rem[proc_slot] != 8'd0);
    // Direction is the pre-load value, so a colliding load cannot alter it.
    issue_byte = {proc_slot, dir[proc_slot], 1'b1, 4'b0000};
  end

  // Next remaining counts/directions: decrement on issue, a load overrides.
  always_comb begin
    rem_next = rem;
    dir_next = dir;
    if (issue) begin
      // issue implies rem != 0, so this never wraps below zero
      rem_next[proc_slot] = rem[proc_slot] - 8'd1;
    end else begin
      rem_next[proc_slot] = rem[proc_slot];
    end
    if (load) begin
      rem_next[idx_lat] = rx_byte;
      dir_next[idx_lat] = dir_lat;
    end else begin
      dir_next[idx_lat] = dir[idx_lat];
    end
    for (int i = 0; i < 4; i++) begin
      busy_next[i] = (rem_next[i] != 8'd0);
    end
  end

  // Free-running tick counter, 0..STEP_DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_ONE;
    end
  end

  // Command parser FSM: header then count, with error pulse on bad header.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pstate  <= P_HDR;
      idx_lat <= 2'd0;
      dir_lat <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      case (pstate)
        P_HDR: begin
          if (rx_valid) begin
            if (rx_byte[7:6] == 2'b10) begin
              idx_lat <= rx_byte[5:4];
              dir_lat <= rx_byte[3];
              pstate  <= P_CNT;
            end else begin
              cmd_err <= 1'b1;
            end
          end
        end
        P_CNT: begin
          if (rx_valid) begin
            pstate <= P_HDR;
          end
        end
        default: pstate <= P_HDR;
      endcase
    end
  end

  // Scheduler FSM with registered control-bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sstate    <= S_IDLE;
      slot      <= 2'd0;
      ctrl_wr   <= 1'b0;
      ctrl_byte <= 8'h00;
    end else begin
      ctrl_wr <= issue;
      if (issue) begin
        ctrl_byte <= issue_byte;
      end
      case (sstate)
        S_IDLE: begin
          if (tick) begin
            sstate <= S_ISSUE;
            slot   <= 2'd1;
          end
        end
        S_ISSUE: begin
          if (slot == 2'd3) begin
            sstate <= S_IDLE;
            slot   <= 2'd0;
          end else begin
            slot <= slot + 2'd1;
          end
        end
        default: begin
          sstate <= S_IDLE;
          slot   <= 2'd0;
        end
      endcase
    end
  end

  // Per-motor counts, directions and the registered busy flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      dir  <= 4'b0000;
      busy <= 4'b0000;
    end else begin
      rem  <= rem_next;
      dir  <= dir_next;
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_stepper_sched.sv
// Self-checking bench for stepper_sched with STEP_DIV=16. Expected control
// writes are queued when commands are sent and popped by a monitor on every
// ctrl_wr; the monitor also checks each write lands on its slot cycle.
module tb_stepper_sched;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] ctrl_byte;
  logic       ctrl_wr;
  logic [3:0] busy;
  logic       cmd_err;

  int         n_checks = 0;
  int         n_errors = 0;
  int         err_pulses = 0;
  int         tc;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  stepper_sched #(.STEP_DIV(DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .ctrl_byte(ctrl_byte),
    .ctrl_wr  (ctrl_wr),
    .busy     (busy),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Bench's own phase reference: tick happens in the cycle where tc == DIV-1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tc <= 0;
    else        tc <= (tc == DIV - 1) ? 0 : tc + 1;
  end

  // Monitor: pop expected write, compare byte and slot timing; count cmd_err.
  always @(negedge clk) begin
    if (rst_n && cmd_err) err_pulses++;
    if (rst_n && ctrl_wr) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_wr", ctrl_wr, 1'b0);
      end else begin
        exp_b = exp_q.pop_front();
        check_eq("ctrl_byte", ctrl_byte, exp_b);
        check_eq("slot_timing", tc, exp_b[7:6]);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tc(input int v);
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge clk);
      if (tc == v) break;
    end
  endtask

  task automatic wait_drain(input string tag, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  task automatic push_n(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(b);
  endtask

  initial begin
    // Reset state
    idle(3);
    check_eq("rst_ctrl_byte", ctrl_byte, 8'h00);
    check_eq("rst_ctrl_wr", ctrl_wr, 1'b0);
    check_eq("rst_busy", busy, 4'b0000);
    check_eq("rst_cmd_err", cmd_err, 1'b0);
    rst_n = 1'b1;
    idle(2);
    check_eq("post_rst_busy", busy, 4'b0000);

    // Motor 1, dir 1, three steps: one 0x70 per tick at tick+2
    wait_tc(4);
    send(8'h98); send(8'h03);
    push_n(8'h70, 3);
    check_eq("t1_busy_load", busy, 4'b0010);
    wait_drain("t1_drain", 80);
    @(negedge clk);
    check_eq("t1_busy_done", busy, 4'b0000);
    idle(2 * DIV);

    // Bad header, then a good one-step command for motor 0
    wait_tc(4);
    send(8'h41);
    check_eq("t2_cmd_err", cmd_err, 1'b1);
    check_eq("t2_busy_bad", busy, 4'b0000);
    @(negedge clk);
    check_eq("t2_cmd_err_1cyc", cmd_err, 1'b0);
    send(8'h80); send(8'h01);
    exp_q.push_back(8'h10);
    check_eq("t2_busy_load", busy, 4'b0001);
    wait_drain("t2_drain", 40);
    @(negedge clk);
    check_eq("t2_busy_done", busy, 4'b0000);
    check_eq("t2_err_pulses", err_pulses, 1);

    // All four motors, two steps each: four consecutive writes per tick
    wait_tc(4);
    send(8'h80); send(8'h02); send(8'h90); send(8'h02);
    send(8'hA0); send(8'h02); send(8'hB8); send(8'h02);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(8'h10); exp_q.push_back(8'h50);
      exp_q.push_back(8'h90); exp_q.push_back(8'hF0);
    end
    check_eq("t3_busy_load", busy, 4'b1111);
    wait_drain("t3_drain", 80);
    @(negedge clk);
    check_eq("t3_busy_done", busy, 4'b0000);
    idle(3 * DIV);

    // Long move on motor 0, stopped by a zero count, then a short one
    wait_tc(4);
    send(8'h80); send(8'hC8);
    push_n(8'h10, 3);
    wait_drain("t4_three", 80);
    wait_tc(4);
    send(8'h80); send(8'h00);
    check_eq("t4_busy_stop", busy, 4'b0000);
    idle(3 * DIV);
    wait_tc(4);
    send(8'h88); send(8'h01);
    exp_q.push_back(8'h30);
    wait_drain("t4_drain", 40);
    @(negedge clk);
    check_eq("t4_busy_done", busy, 4'b0000);

    // Load collides with motor 2's slot: write uses old direction, count 5 kept
    wait_tc(4);
    send(8'hA0); send(8'h03);
    exp_q.push_back(8'h90);
    push_n(8'hB0, 5);
    wait_tc(0);
    send(8'hA8); send(8'h05);
    check_eq("t5_busy_after", busy, 4'b0100);
    wait_drain("t5_drain", 120);
    @(negedge clk);
    check_eq("t5_busy_done", busy, 4'b0000);
    idle(3 * DIV);

    // Reset in the middle of an issue burst
    wait_tc(4);
    send(8'h80); send(8'hFF);
    exp_q.push_back(8'h10);
    wait_tc(0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_ctrl_wr", ctrl_wr, 1'b0);
    check_eq("t6_rst_busy", busy, 4'b0000);
    check_eq("t6_rst_ctrl_byte", ctrl_byte, 8'h00);
    check_eq("t6_first_wr_seen", exp_q.size(), 0);
    idle(3);
    rst_n = 1'b1;
    idle(4 * DIV + 8);
    check_eq("t6_busy_after", busy, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
